// File: rtl/text_pkg.sv
// Shared text-mode constants, the glyph-row type and the character set used
// by the glyph ROM.
package text_pkg;

  localparam int COLS   = 80;
  localparam int ROWS   = 60;
  localparam int CELL_W = 8;
  localparam int CELL_H = 8;
  localparam int TB_AW  = 13;
  localparam int CODE_W = 6;

  typedef logic [CELL_W-1:0] glyph_row_t;

  // Character set: code 0 is blank, code 1 is a pair of vertical bars at the
  // cell edges, code 63 is a solid block; every other code gets a distinct
  // pattern built from its code and row so neighbouring glyphs differ.
  function automatic glyph_row_t glyph_lookup(input logic [CODE_W-1:0] code,
                                              input logic [2:0]        row);
    glyph_row_t g;
    case (code)
      6'd0:    g = 8'h00;
      6'd1:    g = 8'h81;
      6'd63:   g = 8'hFF;
      default: g = {code ^ {3'b000, row}, row[1:0]};
    endcase
    return g;
  endfunction

endpackage

// File: rtl/glyph_rom.sv
// 64-character x 8-row glyph ROM with a registered (1-cycle) read.
// Bit 7 of each row is the leftmost pixel of the cell.
module glyph_rom
  import text_pkg::*;
(
  input  logic       clk,
  input  logic       clr_n,
  input  logic [5:0] code,
  input  logic [2:0] row,
  output logic [7:0] glyph
);

  // Registered lookup at {code, row}; cleared on reset so blank rows follow.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) glyph <= '0;
    else        glyph <= glyph_lookup(code, row);
  end

endmodule

// File: rtl/char_scanout.sv
// Text-mode scan-out: turns VGA pixel coordinates into monochrome RGB through
// a fixed 3-stage pipeline.
//   S0: compute and register the text-buffer address plus the in-cell pixel
//       offsets, visibility and cursor hit.
//   S1: the external text buffer returns the character code in the cycle
//       tb_addr is presented; it addresses the glyph ROM directly, whose
//       output register is this stage.
//   S2: pick the pixel bit, apply the blinking cursor, register RGB.
// Syncs ride a 3-deep shift register so they line up with RGB.
module char_scanout #(
  parameter int         COLS       = text_pkg::COLS,
  parameter int         ROWS       = text_pkg::ROWS,
  parameter logic [3:0] FG         = 4'hF,
  parameter logic [3:0] BG         = 4'h0,
  parameter int         BLINK_LOG2 = 5
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic [9:0]  px_x,
  input  logic [9:0]  px_y,
  input  logic        px_active,
  input  logic        hsync_in,
  input  logic        vsync_in,
  output logic [12:0] tb_addr,
  input  logic [5:0]  tb_data,
  input  logic [6:0]  cur_col,
  input  logic [5:0]  cur_row,
  input  logic        cur_en,
  output logic        hsync,
  output logic        vsync,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue
);

  localparam int PX_W = COLS * text_pkg::CELL_W;
  localparam int PX_H = ROWS * text_pkg::CELL_H;

  logic [6:0]  cell_x;
  logic [6:0]  cell_y;
  logic        in_range;
  logic        cur_hit;
  logic [12:0] addr_next;

  logic [2:0]  s0_xlo;
  logic [2:0]  s0_ylo;
  logic        s0_vis;
  logic        s0_hit;

  logic [7:0]  s1_glyph;
  logic [2:0]  s1_xlo;
  logic        s1_vis;
  logic        s1_hit;

  logic        pix_bit;
  logic        pix_final;
  logic [3:0]  pix_lvl;

  logic [2:0]  hs_sr;
  logic [2:0]  vs_sr;

  logic              vsync_in_q;
  logic [BLINK_LOG2:0] blink_cnt;
  logic              blink_phase;

  assign cell_x    = px_x[9:3];
  assign cell_y    = px_y[9:3];
  assign in_range  = (int'(px_x) < PX_W) && (int'(px_y) < PX_H);
  assign addr_next = 13'(cell_y) * 13'(COLS) + 13'(cell_x);
  assign cur_hit   = cur_en && (cell_x == cur_col) && (cell_y == {1'b0, cur_row});

  // S0: address and side-band capture; the address only moves for on-screen
  // coordinates so the text buffer never sees an out-of-range read.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      tb_addr <= '0;
      s0_xlo  <= '0;
      s0_ylo  <= '0;
      s0_vis  <= 1'b0;
      s0_hit  <= 1'b0;
    end else begin
      if (in_range) tb_addr <= addr_next;
      s0_xlo <= px_x[2:0];
      s0_ylo <= px_y[2:0];
      s0_vis <= px_active && in_range;
      s0_hit <= cur_hit;
    end
  end

  glyph_rom u_glyph_rom (
    .clk   (clk),
    .clr_n (clr_n),
    .code  (tb_data),
    .row   (s0_ylo),
    .glyph (s1_glyph)
  );

  // S1: side-band travels alongside the glyph-ROM read.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      s1_xlo <= '0;
      s1_vis <= 1'b0;
      s1_hit <= 1'b0;
    end else begin
      s1_xlo <= s0_xlo;
      s1_vis <= s0_vis;
      s1_hit <= s0_hit;
    end
  end

  assign pix_bit   = s1_glyph[3'd7 - s1_xlo];
  assign pix_final = pix_bit ^ (s1_hit & blink_phase);

  // S2: final colour; off-screen or blanked pixels are forced black.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)      pix_lvl <= 4'h0;
    else if (s1_vis) pix_lvl <= pix_final ? FG : BG;
    else             pix_lvl <= 4'h0;
  end

  assign red   = pix_lvl;
  assign green = pix_lvl;
  assign blue  = pix_lvl;

  // Sync delay line; resets to the inactive (high) level.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      hs_sr <= 3'b111;
      vs_sr <= 3'b111;
    end else begin
      hs_sr <= {hs_sr[1:0], hsync_in};
      vs_sr <= {vs_sr[1:0], vsync_in};
    end
  end

  assign hsync = hs_sr[2];
  assign vsync = vs_sr[2];

  // Frame counter for the cursor blink: advances on each vsync_in falling
  // edge and wraps freely; its MSB is the blink phase.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      vsync_in_q <= 1'b1;
      blink_cnt  <= '0;
    end else begin
      vsync_in_q <= vsync_in;
      if (vsync_in_q && !vsync_in) blink_cnt <= blink_cnt + 1'b1;
    end
  end

  assign blink_phase = blink_cnt[BLINK_LOG2];

endmodule

// File: tb/tb_char_scanout.sv
// Bench for char_scanout: a text-buffer memory, a pixel-level reference model
// and an expected-output queue that is three cycles deep.
module tb_char_scanout;

  logic        clk;
  logic        clr_n;
  logic [9:0]  px_x;
  logic [9:0]  px_y;
  logic        px_active;
  logic        hsync_in;
  logic        vsync_in;
  logic [12:0] tb_addr;
  logic [5:0]  tb_data;
  logic [6:0]  cur_col;
  logic [5:0]  cur_row;
  logic        cur_en;
  logic        hsync;
  logic        vsync;
  logic [3:0]  red;
  logic [3:0]  green;
  logic [3:0]  blue;

  logic [5:0]  tb_mem [0:4799];
  logic [13:0] exp_q[$];
  int          n_vec;
  int          n_err;
  int          m_frames;
  int          m_addr;
  bit          m_prev_vs;

  char_scanout dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .px_x      (px_x),
    .px_y      (px_y),
    .px_active (px_active),
    .hsync_in  (hsync_in),
    .vsync_in  (vsync_in),
    .tb_addr   (tb_addr),
    .tb_data   (tb_data),
    .cur_col   (cur_col),
    .cur_row   (cur_row),
    .cur_en    (cur_en),
    .hsync     (hsync),
    .vsync     (vsync),
    .red       (red),
    .green     (green),
    .blue      (blue)
  );

  // Text buffer: code for the address currently presented.
  assign tb_data = (int'(tb_addr) < 4800) ? tb_mem[int'(tb_addr)] : 6'd0;

  // Clock: 25 MHz.
  initial begin
    clk = 1'b0;
    forever #20 clk = ~clk;
  end

  function automatic int model_glyph(input int code, input int r);
    if (code == 0)  return 0;
    if (code == 1)  return 8'h81;
    if (code == 63) return 8'hFF;
    return (((code ^ r) << 2) | (r % 4)) & 255;
  endfunction

  function automatic logic [3:0] model_pix(input int x, input int y, input bit act);
    int col;
    int row;
    int gr;
    int p;
    if (!act || x >= 640 || y >= 480) return 4'h0;
    col = x / 8;
    row = y / 8;
    gr  = model_glyph(int'(tb_mem[row * 80 + col]), y % 8);
    p   = (gr >> (7 - (x % 8))) & 1;
    if (cur_en && col == int'(cur_col) && row == int'(cur_row) && (((m_frames / 32) % 2) == 1))
      p = p ^ 1;
    return (p != 0) ? 4'hF : 4'h0;
  endfunction

  // Drive one cycle of inputs, queue its expected output, step one clock and
  // hand back the expectation for what is now on the outputs.
  task automatic apply(input int x, input int y, input bit act, input bit hs, input bit vs,
                       output logic [13:0] exp_now, output bit have_exp);
    logic [3:0] pix;
    px_x      = 10'(x);
    px_y      = 10'(y);
    px_active = act;
    hsync_in  = hs;
    vsync_in  = vs;
    pix = model_pix(x, y, act);
    exp_q.push_back({hs, vs, pix, pix, pix});
    if (m_prev_vs && !vs) m_frames = (m_frames + 1) % 64;
    m_prev_vs = vs;
    if (x < 640 && y < 480) m_addr = (y / 8) * 80 + (x / 8);
    @(posedge clk);
    #1;
    have_exp = 1'b0;
    exp_now  = '0;
    if (exp_q.size() >= 3) begin
      exp_now  = exp_q.pop_front();
      have_exp = 1'b1;
    end
  endtask

  task automatic advance_frames(input int n);
    logic [13:0] e;
    bit h;
    for (int f = 0; f < n; f++) begin
      for (int k = 0; k < 2; k++) begin
        apply(0, 0, 1'b0, 1'b1, (k == 0), e, h);
        if (h) begin
          n_vec++;
          if ({hsync, vsync, red, green, blue} !== e) begin
            n_err++;
            $display("FAIL frame_adv f=%0d got=%h exp=%h", f, {hsync, vsync, red, green, blue}, e);
          end
        end
      end
    end
  endtask

  task automatic test_reset;
    px_x = '0; px_y = '0; px_active = 1'b0;
    hsync_in = 1'b0; vsync_in = 1'b0;
    cur_col = '0; cur_row = '0; cur_en = 1'b0;
    clr_n = 1'b1;
    #5 clr_n = 1'b0;
    #1;
    n_vec++;
    if ({hsync, vsync, red, green, blue} !== {2'b11, 12'h000}) begin
      n_err++;
      $display("FAIL reset_async got=%h exp=%h", {hsync, vsync, red, green, blue}, {2'b11, 12'h000});
    end
    n_vec++;
    if (tb_addr !== 13'd0) begin
      n_err++;
      $display("FAIL reset_addr got=%0d exp=0", tb_addr);
    end
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({hsync, vsync, red, green, blue} !== {2'b11, 12'h000}) begin
      n_err++;
      $display("FAIL reset_held got=%h exp=%h", {hsync, vsync, red, green, blue}, {2'b11, 12'h000});
    end
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    @(negedge clk);
    clr_n = 1'b1;
    exp_q.delete();
    repeat (2) exp_q.push_back({2'b11, 12'h000});
    m_frames = 0; m_prev_vs = 1'b1; m_addr = 0;
  endtask

  task automatic test_glyph_row;
    logic [13:0] e;
    bit h;
    logic [3:0] pattern [8];
    pattern = '{4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF};
    for (int i = 0; i < 11; i++) begin
      if (i < 8) apply(i, 0, 1'b1, 1'b1, 1'b1, e, h);
      else       apply(0, 0, 1'b0, 1'b1, 1'b1, e, h);
      if (h) begin
        n_vec++;
        if ({hsync, vsync, red, green, blue} !== e) begin
          n_err++;
          $display("FAIL glyph_row i=%0d got=%h exp=%h", i, {hsync, vsync, red, green, blue}, e);
        end
      end
      // Pixel i-2 is on the outputs now (queue stays two entries ahead).
      if (i >= 2 && i < 10) begin
        n_vec++;
        if (red !== pattern[i-2]) begin
          n_err++;
          $display("FAIL glyph_pattern x=%0d got=%h exp=%h", i - 2, red, pattern[i-2]);
        end
      end
    end
  endtask

  task automatic test_addr_bound;
    logic [13:0] e;
    bit h;
    int xs [3];
    int ys [3];
    xs = '{639, 640, 639};
    ys = '{479, 479, 480};
    for (int i = 0; i < 6; i++) begin
      if (i < 3) apply(xs[i], ys[i], 1'b1, 1'b1, 1'b1, e, h);
      else       apply(0, 0, 1'b0, 1'b1, 1'b1, e, h);
      if (h) begin
        n_vec++;
        if ({hsync, vsync, red, green, blue} !== e) begin
          n_err++;
          $display("FAIL addr_bound_rgb i=%0d got=%h exp=%h", i, {hsync, vsync, red, green, blue}, e);
        end
      end
      if (i < 3) begin
        n_vec++;
        if (tb_addr !== 13'd4799) begin
          n_err++;
          $display("FAIL addr_bound i=%0d got=%0d exp=4799", i, tb_addr);
        end
      end
    end
  endtask

  task automatic test_inactive;
    logic [13:0] e;
    bit h;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 66; i++) begin
        if (i < 64) apply(40 + (i % 8), 24 + (i / 8), (pass == 1), 1'b1, 1'b1, e, h);
        else        apply(0, 0, 1'b0, 1'b1, 1'b1, e, h);
        if (h) begin
          n_vec++;
          if ({hsync, vsync, red, green, blue} !== e) begin
            n_err++;
            $display("FAIL inactive pass=%0d i=%0d got=%h exp=%h", pass, i, {hsync, vsync, red, green, blue}, e);
          end
        end
      end
    end
  endtask

  task automatic test_hsync_pulse;
    logic [13:0] e;
    bit h;
    int lows;
    int first_low;
    lows = 0;
    first_low = -1;
    cur_en = 1'b0;
    for (int i = 0; i < 110; i++) begin
      apply($urandom_range(0, 639), $urandom_range(0, 479), 1'b1, !(i >= 5 && i < 101), 1'b1, e, h);
      if (h) begin
        n_vec++;
        if ({hsync, vsync, red, green, blue} !== e) begin
          n_err++;
          $display("FAIL hsync_pulse i=%0d got=%h exp=%h", i, {hsync, vsync, red, green, blue}, e);
        end
      end
      // This sample lies inside cycle i+1.
      if (hsync === 1'b0) begin
        lows++;
        if (first_low < 0) first_low = i + 1;
      end
    end
    n_vec++;
    if (lows !== 96) begin
      n_err++;
      $display("FAIL hsync_width got=%0d exp=96", lows);
    end
    n_vec++;
    if (first_low !== 8) begin
      n_err++;
      $display("FAIL hsync_start got=%0d exp=8", first_low);
    end
  endtask

  task automatic test_cursor_blink;
    logic [13:0] e;
    bit h;
    int lit;
    int want [2];
    want = '{64, 0};
    cur_en = 1'b1; cur_col = 7'd2; cur_row = 6'd1;
    for (int pass = 0; pass < 2; pass++) begin
      advance_frames(32);
      lit = 0;
      for (int i = 0; i < 66; i++) begin
        if (i < 64) apply(16 + (i % 8), 8 + (i / 8), 1'b1, 1'b1, 1'b1, e, h);
        else        apply(0, 0, 1'b0, 1'b1, 1'b1, e, h);
        if (h) begin
          n_vec++;
          if ({hsync, vsync, red, green, blue} !== e) begin
            n_err++;
            $display("FAIL cursor pass=%0d i=%0d got=%h exp=%h", pass, i, {hsync, vsync, red, green, blue}, e);
          end
        end
        if (red === 4'hF) lit++;
      end
      n_vec++;
      if (lit !== want[pass]) begin
        n_err++;
        $display("FAIL cursor_count pass=%0d got=%0d exp=%0d", pass, lit, want[pass]);
      end
    end
    advance_frames(32);
  endtask

  task automatic test_random;
    logic [13:0] e;
    bit h;
    int x;
    int y;
    for (int i = 0; i < 300; i++) begin
      x = $urandom_range(0, 700);
      y = $urandom_range(0, 510);
      if ($urandom_range(0, 1) == 1) begin
        cur_col = 7'(x / 8);
        cur_row = 6'(y / 8);
      end else begin
        cur_col = 7'($urandom_range(0, 127));
        cur_row = 6'($urandom_range(0, 63));
      end
      cur_en = 1'($urandom_range(0, 1));
      apply(x, y, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'b1, e, h);
      if (h) begin
        n_vec++;
        if ({hsync, vsync, red, green, blue} !== e) begin
          n_err++;
          $display("FAIL random i=%0d got=%h exp=%h", i, {hsync, vsync, red, green, blue}, e);
        end
      end
      n_vec++;
      if (tb_addr !== 13'(m_addr)) begin
        n_err++;
        $display("FAIL random_addr i=%0d got=%0d exp=%0d", i, tb_addr, m_addr);
      end
    end
  endtask

  task automatic test_reset_midline;
    logic [13:0] e;
    bit h;
    int lit;
    cur_en = 1'b1; cur_col = 7'd2; cur_row = 6'd1;
    for (int i = 0; i < 6; i++) begin
      apply(16 + i, 8, 1'b1, 1'b0, 1'b1, e, h);
      if (h) begin
        n_vec++;
        if ({hsync, vsync, red, green, blue} !== e) begin
          n_err++;
          $display("FAIL pre_reset i=%0d got=%h exp=%h", i, {hsync, vsync, red, green, blue}, e);
        end
      end
    end
    #5 clr_n = 1'b0;
    #1;
    n_vec++;
    if ({hsync, vsync, red, green, blue} !== {2'b11, 12'h000}) begin
      n_err++;
      $display("FAIL midline_async got=%h exp=%h", {hsync, vsync, red, green, blue}, {2'b11, 12'h000});
    end
    @(posedge clk);
    #1;
    hsync_in = 1'b1;
    @(negedge clk);
    clr_n = 1'b1;
    exp_q.delete();
    repeat (2) exp_q.push_back({2'b11, 12'h000});
    m_frames = 0; m_prev_vs = 1'b1; m_addr = 0;
    lit = 0;
    for (int i = 0; i < 11; i++) begin
      if (i < 8) apply(16 + i, 8, 1'b1, 1'b1, 1'b1, e, h);
      else       apply(8, 0, 1'b1, 1'b1, 1'b1, e, h);
      if (h) begin
        n_vec++;
        if ({hsync, vsync, red, green, blue} !== e) begin
          n_err++;
          $display("FAIL post_reset i=%0d got=%h exp=%h", i, {hsync, vsync, red, green, blue}, e);
        end
      end
      if (i < 10 && red === 4'hF) lit++;
    end
    n_vec++;
    if (lit !== 0) begin
      n_err++;
      $display("FAIL blink_cleared got=%0d exp=0", lit);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    for (int i = 0; i < 4800; i++) tb_mem[i] = 6'($urandom_range(0, 63));
    tb_mem[0]          = 6'd1;
    tb_mem[1 * 80 + 2] = 6'd0;
    tb_mem[3 * 80 + 5] = 6'd63;

    test_reset;
    test_glyph_row;
    test_addr_bound;
    test_inactive;
    test_hsync_pulse;
    test_cursor_blink;
    test_random;
    test_reset_midline;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
